// File: rtl/rr_resource_scheduler.sv
// rr_resource_scheduler: 8-way round-robin scheduler granting one owner at a time.
// Define RR_SCHED_QUANTUM_EN to add quantum-based preemption (hold counter, lock, preempt).
module rr_resource_scheduler #(
    parameter int QUANTUM = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       lock,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_gnt, w_gnt_nxt;
    logic [2:0] r_id, w_id_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic       r_busy;
    logic [2:0] w_win;
    logic       w_own;
    logic       w_release;
`ifdef RR_SCHED_QUANTUM_EN
    localparam logic [7:0] Q = 8'(QUANTUM);
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_preempt, w_pre_nxt;
    assign w_release = (r_cnt == Q) && !lock && |(req & ~r_gnt);
`else
    logic w_unused;
    assign w_unused  = &{1'b0, lock, 32'(QUANTUM)};
    assign w_release = 1'b0;
`endif
    assign w_own = req[r_id];
    // Descending scan so the requester closest to ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int i = 7; i >= 0; i--)
            if (req[r_ptr + 3'(i)]) w_win = r_ptr + 3'(i);
    end
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_id;
        w_ptr_nxt   = r_ptr;
        if (r_state == IDLE) begin
            if (|req) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = 8'b1 << w_win;
                w_id_nxt    = w_win;
                w_ptr_nxt   = w_win + 3'd1;
            end
        end else if (!w_own || w_release) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_id    <= w_id_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= |w_gnt_nxt;
        end
    end
`ifdef RR_SCHED_QUANTUM_EN
    always_comb begin
        w_cnt_nxt = (r_state == IDLE) ? (|req ? 8'd1 : r_cnt)
                                      : ((r_cnt == Q) ? r_cnt : r_cnt + 8'd1);
        w_pre_nxt = (r_state == GRANT) && w_own && w_release;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_preempt <= w_pre_nxt;
        end
    end
    assign preempt = r_preempt;
`else
    assign preempt = 1'b0;
`endif
    assign gnt    = r_gnt;
    assign gnt_id = r_id;
    assign busy   = r_busy;
endmodule
